// File: rtl/ram_matrix_fill_ctrl.sv
// ram_matrix_fill_ctrl: arbitrates rectangle fills and host pixel writes onto one frame-buffer write port
module ram_matrix_fill_ctrl #(
    parameter int WordSize    = 8,
    parameter int Rows_Bus    = 10,
    parameter int Columns_Bus = 10,
    parameter int HostBurst   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [Rows_Bus-1:0]    i_cmd_row0,
    input  logic [Rows_Bus-1:0]    i_cmd_row1,
    input  logic [Columns_Bus-1:0] i_cmd_col0,
    input  logic [Columns_Bus-1:0] i_cmd_col1,
    input  logic [WordSize-1:0]    i_cmd_color,
    input  logic                   i_px_valid,
    output logic                   o_px_ready,
    input  logic [Rows_Bus-1:0]    i_px_row,
    input  logic [Columns_Bus-1:0] i_px_col,
    input  logic [WordSize-1:0]    i_px_data,
    output logic                   o_we,
    output logic [Rows_Bus-1:0]    o_waddr_row,
    output logic [Columns_Bus-1:0] o_waddr_col,
    output logic [WordSize-1:0]    o_write,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int SW = $clog2(HostBurst + 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state, state_n;
    logic [Rows_Bus-1:0]    row_lo, row_hi, cur_row;
    logic [Columns_Bus-1:0] col_lo, col_hi, cur_col;
    logic [WordSize-1:0]    color;
    logic [SW-1:0]          streak;
    logic                   host_gnt, fill_gnt, cmd_acc, last_cell;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        o_cmd_ready = state == IDLE;
        o_px_ready  = (state == IDLE) || (streak != SW'(HostBurst));
        o_busy      = state == FILL;
        host_gnt    = i_px_valid && o_px_ready;
        fill_gnt    = (state == FILL) && !host_gnt;
        cmd_acc     = i_cmd_valid && o_cmd_ready;
        last_cell   = (cur_row == row_hi) && (cur_col == col_hi);
        state_n     = cmd_acc ? FILL : (fill_gnt && last_cell) ? IDLE : state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_we        <= 1'b0;
            o_done      <= 1'b0;
            o_waddr_row <= '0;
            o_waddr_col <= '0;
            o_write     <= '0;
            streak      <= '0;
            row_lo      <= '0;
            row_hi      <= '0;
            col_lo      <= '0;
            col_hi      <= '0;
            cur_row     <= '0;
            cur_col     <= '0;
            color       <= '0;
        end else begin
            o_we   <= host_gnt || fill_gnt;
            o_done <= fill_gnt && last_cell;
            streak <= (state == IDLE || fill_gnt) ? '0 : host_gnt ? streak + SW'(1) : streak;
            if (host_gnt) begin
                o_waddr_row <= i_px_row;
                o_waddr_col <= i_px_col;
                o_write     <= i_px_data;
            end else if (fill_gnt) begin
                o_waddr_row <= cur_row;
                o_waddr_col <= cur_col;
                o_write     <= color;
            end
            // the cursor only moves when the fill itself owns the port
            if (cmd_acc) begin
                row_lo  <= (i_cmd_row0 < i_cmd_row1) ? i_cmd_row0 : i_cmd_row1;
                row_hi  <= (i_cmd_row0 < i_cmd_row1) ? i_cmd_row1 : i_cmd_row0;
                col_lo  <= (i_cmd_col0 < i_cmd_col1) ? i_cmd_col0 : i_cmd_col1;
                col_hi  <= (i_cmd_col0 < i_cmd_col1) ? i_cmd_col1 : i_cmd_col0;
                cur_row <= (i_cmd_row0 < i_cmd_row1) ? i_cmd_row0 : i_cmd_row1;
                cur_col <= (i_cmd_col0 < i_cmd_col1) ? i_cmd_col0 : i_cmd_col1;
                color   <= i_cmd_color;
            end else if (fill_gnt && !last_cell) begin
                cur_col <= (cur_col < col_hi) ? cur_col + Columns_Bus'(1) : col_lo;
                cur_row <= (cur_col < col_hi) ? cur_row : cur_row + Rows_Bus'(1);
            end
        end
    end
endmodule

// File: tb/tb_ram_matrix_fill_ctrl.sv
// tb_ram_matrix_fill_ctrl: cycle-exact scoreboard of RAM-port writes for fills and host pixels
module tb_ram_matrix_fill_ctrl;
    localparam int WS = 8;
    localparam int RB = 10;
    localparam int CB = 10;
    localparam int HB = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [RB-1:0] i_cmd_row0 = '0, i_cmd_row1 = '0;
    logic [CB-1:0] i_cmd_col0 = '0, i_cmd_col1 = '0;
    logic [WS-1:0] i_cmd_color = '0;
    logic          i_px_valid = 1'b0;
    logic          o_px_ready;
    logic [RB-1:0] i_px_row = '0;
    logic [CB-1:0] i_px_col = '0;
    logic [WS-1:0] i_px_data = '0;
    logic          o_we;
    logic [RB-1:0] o_waddr_row;
    logic [CB-1:0] o_waddr_col;
    logic [WS-1:0] o_write;
    logic          o_busy;
    logic          o_done;

    ram_matrix_fill_ctrl #(.WordSize(WS), .Rows_Bus(RB), .Columns_Bus(CB), .HostBurst(HB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_row0(i_cmd_row0), .i_cmd_row1(i_cmd_row1),
        .i_cmd_col0(i_cmd_col0), .i_cmd_col1(i_cmd_col1), .i_cmd_color(i_cmd_color),
        .i_px_valid(i_px_valid), .o_px_ready(o_px_ready),
        .i_px_row(i_px_row), .i_px_col(i_px_col), .i_px_data(i_px_data),
        .o_we(o_we), .o_waddr_row(o_waddr_row), .o_waddr_col(o_waddr_col), .o_write(o_write),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int cyc; int row; int col; int data; int done; } wr_t;
    typedef struct { int r0; int r1; int c0; int c1; int color; int cells; } cmd_t;
    typedef struct { int row; int col; int data; } px_t;

    wr_t exp_q[$];
    int  cyc = 0, total = 0, bad = 0, nwr = 0;
    bit  mon_en = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int r, input int col, input int d, input int dn);
        wr_t w;
        w.cyc = c; w.row = r; w.col = col; w.data = d; w.done = dn;
        exp_q.push_back(w);
    endtask

    // every write must land on exactly its predicted cycle; any other cycle must be quiet
    always @(negedge i_clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_write_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                wr_t w;
                w = exp_q.pop_front();
                chk("we", int'(o_we), 1);
                chk("row", int'(o_waddr_row), w.row);
                chk("col", int'(o_waddr_col), w.col);
                chk("data", int'(o_write), w.data);
                chk("done", int'(o_done), w.done);
                if (o_we) nwr++;
            end else begin
                chk("quiet_we", int'(o_we), 0);
                chk("quiet_done", int'(o_done), 0);
            end
        end
    end

    task automatic run_cmd(input cmd_t c);
        int t0, rl, rh, cl, ch, k, n0;
        @(negedge i_clk);
        chk("cmd_ready_idle", int'(o_cmd_ready), 1);
        i_cmd_valid = 1'b1;
        i_cmd_row0 = RB'(c.r0); i_cmd_row1 = RB'(c.r1);
        i_cmd_col0 = CB'(c.c0); i_cmd_col1 = CB'(c.c1);
        i_cmd_color = WS'(c.color);
        t0 = cyc;
        n0 = nwr;
        rl = (c.r0 < c.r1) ? c.r0 : c.r1;
        rh = (c.r0 < c.r1) ? c.r1 : c.r0;
        cl = (c.c0 < c.c1) ? c.c0 : c.c1;
        ch = (c.c0 < c.c1) ? c.c1 : c.c0;
        k = 0;
        for (int r = rl; r <= rh; r++)
            for (int cc = cl; cc <= ch; cc++) begin
                push(t0 + 2 + k, r, cc, c.color, int'(r == rh && cc == ch));
                k++;
            end
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        chk("busy_first", int'(o_busy), 1);
        repeat (k - 1) @(negedge i_clk);
        chk("busy_last", int'(o_busy), 1);
        @(negedge i_clk);
        chk("busy_after", int'(o_busy), 0);
        chk("cmd_ready_after", int'(o_cmd_ready), 1);
        @(negedge i_clk);
        chk("cells", nwr - n0, c.cells);
    endtask

    cmd_t cmds[4];
    px_t  pxs[4];

    initial begin
        int t0, k, pr, pd;
        bit guard;
        cmds[0] = '{5, 3, 7, 2, 'hA5, 18};
        cmds[1] = '{0, 0, 1023, 1020, 'h3C, 4};
        cmds[2] = '{1023, 1022, 0, 0, 'h81, 2};
        cmds[3] = '{2, 6, 4, 4, 'h0F, 5};
        pxs[0] = '{1023, 1023, 'h3C};
        pxs[1] = '{0, 0, 'hFF};
        pxs[2] = '{512, 1, 'h00};
        pxs[3] = '{7, 900, 'h5A};

        @(posedge i_clk);
        mon_en = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_row", int'(o_waddr_row), 0);
        chk("rst_col", int'(o_waddr_col), 0);
        chk("rst_data", int'(o_write), 0);
        repeat (5) begin
            @(negedge i_clk);
            chk("idle_cmd_ready", int'(o_cmd_ready), 1);
            chk("idle_px_ready", int'(o_px_ready), 1);
            chk("idle_busy", int'(o_busy), 0);
        end

        foreach (cmds[i]) run_cmd(cmds[i]);

        // isolated single pixel, then a back-to-back stream
        @(negedge i_clk);
        i_px_valid = 1'b1;
        i_px_row = RB'(pxs[0].row); i_px_col = CB'(pxs[0].col); i_px_data = WS'(pxs[0].data);
        push(cyc + 1, pxs[0].row, pxs[0].col, pxs[0].data, 0);
        @(negedge i_clk);
        i_px_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        foreach (pxs[i]) begin
            chk("px_ready_stream", int'(o_px_ready), 1);
            i_px_valid = 1'b1;
            i_px_row = RB'(pxs[i].row); i_px_col = CB'(pxs[i].col); i_px_data = WS'(pxs[i].data);
            push(cyc + 1, pxs[i].row, pxs[i].col, pxs[i].data, 0);
            @(negedge i_clk);
        end
        i_px_valid = 1'b0;
        repeat (3) @(negedge i_clk);

        // fill (0,0)-(0,9) against a host that never lets go
        k = 0;
        t0 = 0;
        for (int j = -1; j < 50; j++) begin
            if (j == -1) begin
                t0 = cyc;
                i_cmd_valid = 1'b1;
                i_cmd_row0 = '0; i_cmd_row1 = '0;
                i_cmd_col0 = '0; i_cmd_col1 = CB'(9);
                i_cmd_color = 8'hC3;
            end else i_cmd_valid = 1'b0;
            guard = (j >= 0) && (j % 5 == 4);
            chk("hold_px_ready", int'(o_px_ready), int'(!guard));
            pr = 200 + j + 1;
            pd = (j + 17) & 'hFF;
            i_px_valid = 1'b1;
            i_px_row = RB'(pr); i_px_col = CB'(300); i_px_data = WS'(pd);
            if (!guard) push(cyc + 1, pr, 300, pd, 0);
            else begin
                push(cyc + 1, 0, k, 'hC3, int'(k == 9));
                k++;
            end
            @(negedge i_clk);
        end
        i_px_valid = 1'b0;
        chk("hold_end_cycle", cyc - t0, 51);
        chk("hold_busy_after", int'(o_busy), 0);
        repeat (3) @(negedge i_clk);

        // command and pixel in the same idle cycle, 1x1 rectangle
        t0 = cyc;
        i_cmd_valid = 1'b1;
        i_cmd_row0 = RB'(7); i_cmd_row1 = RB'(7);
        i_cmd_col0 = CB'(7); i_cmd_col1 = CB'(7);
        i_cmd_color = 8'h11;
        i_px_valid = 1'b1;
        i_px_row = RB'(1); i_px_col = CB'(2); i_px_data = 8'h22;
        push(t0 + 1, 1, 2, 'h22, 0);
        push(t0 + 2, 7, 7, 'h11, 1);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_px_valid = 1'b0;
        repeat (4) @(negedge i_clk);

        // reset lands after the third write of a 4x4 fill
        t0 = cyc;
        i_cmd_valid = 1'b1;
        i_cmd_row0 = '0; i_cmd_row1 = RB'(3);
        i_cmd_col0 = '0; i_cmd_col1 = CB'(3);
        i_cmd_color = 8'h5A;
        for (int i = 0; i < 3; i++) push(t0 + 2 + i, 0, i, 'h5A, 0);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_mid_cmd_ready", int'(o_cmd_ready), 1);
        chk("rst_mid_busy", int'(o_busy), 0);
        chk("rst_mid_row", int'(o_waddr_row), 0);
        repeat (20) @(negedge i_clk);
        run_cmd('{2, 1, 1, 2, 'h77, 4});

        repeat (5) @(negedge i_clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
